// File: rtl/pe_stream_pkg.sv
// Shared field layout and FSM encoding for the PE input streamer.
// Covers the command word, the input_port message and the controller states.
package pe_stream_pkg;

    localparam int unsigned CMD_W        = 25;
    localparam int unsigned CMD_BASE_LSB = 0;
    localparam int unsigned CMD_BASE_W   = 16;
    localparam int unsigned CMD_NUM_LSB  = 16;
    localparam int unsigned CMD_NUM_W    = 8;
    localparam int unsigned CMD_BANK_BIT = 24;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned IDX_LSB  = 128;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned BANK_BIT = 136;
    localparam int unsigned LAST_BIT = 137;
    localparam int unsigned MSG_W    = 138;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic [MSG_W-1:0] pack_msg(input logic [DATA_W-1:0] data,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic              bank,
                                                  input logic              last);
        logic [MSG_W-1:0] msg;
        msg                         = '0;
        msg[DATA_W-1:0]             = data;
        msg[IDX_LSB +: IDX_W]       = idx;
        msg[BANK_BIT]               = bank;
        msg[LAST_BIT]               = last;
        return msg;
    endfunction

endpackage

// File: rtl/pe_stream_fifo.sv
// Synchronous FIFO for memory read data; head is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module pe_stream_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign wr_en = push_i & ~full_o;
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
        count_d  = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pe_input_streamer.sv
// Streams num_vec vectors from the global buffer into the PE input_port.
// Outstanding reads are capped by FIFO space, so responses never need back-pressure.
module pe_input_streamer
    import pe_stream_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CMD_W-1:0]   cmd_msg,
    input  logic               cmd_val,
    output logic               cmd_rdy,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic               mem_req_val,
    input  logic               mem_req_rdy,
    input  logic [DATA_W-1:0]  mem_rsp_data,
    input  logic               mem_rsp_val,
    output logic [MSG_W-1:0]   input_port_msg,
    output logic               input_port_val,
    input  logic               input_port_rdy,
    output logic               done_msg,
    output logic               done_val,
    input  logic               done_rdy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        num_q, num_d;
    logic              bank_q, bank_d;
    logic [7:0]        issue_cnt_q, issue_cnt_d;
    logic [7:0]        out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              req_val_q, req_val_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              cmd_fire, req_fire, rsp_push, beat_fire, beat_last;
    logic [CNT_W:0]    used;

    assign cmd_rdy        = (state_q == StIdle);
    assign cmd_fire       = cmd_val & cmd_rdy;
    assign req_fire       = req_val_q & mem_req_rdy;
    assign rsp_push       = mem_rsp_val & (inflight_q != '0);
    assign input_port_val = ~fifo_empty;
    assign beat_fire      = input_port_val & input_port_rdy;
    assign beat_last      = (out_cnt_q == num_q - 8'd1);
    assign input_port_msg = input_port_val ? pack_msg(fifo_head, out_cnt_q, bank_q, beat_last)
                                           : '0;
    assign mem_req_val    = req_val_q;
    assign mem_req_addr   = req_addr_q;
    assign done_val       = (state_q == StDone);
    assign done_msg       = 1'b1;

    // A pending request already holds a credit; pops this cycle are deliberately not counted.
    assign used = {1'b0, fifo_count} + {1'b0, inflight_q} + (CNT_W+1)'(req_fire);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        bank_d      = bank_q;
        issue_cnt_d = issue_cnt_q + 8'(req_fire);
        out_cnt_d   = out_cnt_q + 8'(beat_fire);
        inflight_d  = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_push);
        req_val_d   = req_val_q;
        req_addr_d  = req_addr_q;

        if (!(req_val_q && !mem_req_rdy)) begin
            req_val_d = (state_q == StRun) && (issue_cnt_d < num_q) &&
                        (used < (CNT_W+1)'(FIFO_DEPTH));
            if (req_val_d) begin
                req_addr_d = base_q + ADDR_W'(issue_cnt_d);
            end
        end

        case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    base_d      = ADDR_W'(cmd_msg[CMD_BASE_LSB +: CMD_BASE_W]);
                    num_d       = cmd_msg[CMD_NUM_LSB +: CMD_NUM_W];
                    bank_d      = cmd_msg[CMD_BANK_BIT];
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    if (cmd_msg[CMD_NUM_LSB +: CMD_NUM_W] == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StRun;
                        req_val_d  = 1'b1;
                        req_addr_d = ADDR_W'(cmd_msg[CMD_BASE_LSB +: CMD_BASE_W]);
                    end
                end
            end
            StRun: begin
                if (beat_fire && beat_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (done_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            num_q       <= '0;
            bank_q      <= 1'b0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= '0;
            req_val_q   <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            bank_q      <= bank_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            req_val_q   <= req_val_d;
            req_addr_q  <= req_addr_d;
        end
    end

    pe_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_push),
        .push_data_i (mem_rsp_data),
        .pop_i       (beat_fire),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rsp_val && inflight_q == '0));
    no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_push && fifo_full && !beat_fire));

endmodule
